// File: rtl/alu_sequencer.sv
// Purpose : drives a 4-bit external ALU one nibble at a time, LSB first, to build a full-width result.
// Latency : NIBBLES+1 cycles from the edge that accepts start to the done pulse.
// Backpres: none; start is sampled only in IDLE, and a start seen while busy is dropped.
//
// Ports
//   i_clk, i_reset        clock; asynchronous active-low reset
//   i_start               request an operation (sampled only in IDLE)
//   i_op_a, i_op_b        full-width operands, latched when start is accepted
//   i_op, i_bank, i_cin   ALU opcode, bank and carry-in, latched when start is accepted
//   o_busy, o_done        operation in progress / one-cycle completion pulse
//   o_result, o_flags     full-width result and NZVC flags (bit3 N, bit2 Z, bit1 V, bit0 C)
//   o_alu_*               nibble operands, opcode, bank, carry and active-low enable driven to the ALU
//   i_alu_result          nibble result returned by the ALU
//   i_alu_flags           nibble NZVC returned by the ALU
//
// Build option: define ALU_SEQ_ZCHAIN_EN to make the final Z a whole-word zero
// (the AND of every nibble's Z). Without it, Z is the last nibble's Z only.
// Legal NIBBLES range is 2..8.

module alu_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [4*NIBBLES-1:0] i_op_a,
    input  logic [4*NIBBLES-1:0] i_op_b,
    input  logic [2:0]           i_op,
    input  logic                 i_bank,
    input  logic                 i_cin,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [4*NIBBLES-1:0] o_result,
    output logic [3:0]           o_flags,
    output logic [3:0]           o_alu_a,
    output logic [3:0]           o_alu_b,
    output logic [2:0]           o_alu_op,
    output logic                 o_alu_bank,
    output logic                 o_alu_cin,
    output logic                 o_alu_enable,
    input  logic [3:0]           i_alu_result,
    input  logic [3:0]           i_alu_flags
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // Operands and controls latched at the accepting edge
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [2:0]      r_op;
    logic            r_bank;
    logic            r_cin;

    logic [IW-1:0]   r_idx;
    logic            r_carry;   // carry out of the previous nibble
    logic [W-1:0]    r_result;
    logic [3:0]      r_flags;
`ifdef ALU_SEQ_ZCHAIN_EN
    logic            r_zacc;    // AND of Z over the nibbles captured so far
`endif

    logic            w_accept;
    logic            w_last;
    logic [W-1:0]    w_shift_a;
    logic [W-1:0]    w_shift_b;
    logic [3:0]      w_nib_a;
    logic [3:0]      w_nib_b;
    logic            w_z_final;

    assign w_accept  = (r_state == S_IDLE) && i_start;
    assign w_last    = (r_idx == IW'(NIBBLES - 1));

    // Select the current nibble by shifting it down to bit 0
    assign w_shift_a = r_a >> {r_idx, 2'b00};
    assign w_shift_b = r_b >> {r_idx, 2'b00};
    assign w_nib_a   = w_shift_a[3:0];
    assign w_nib_b   = w_shift_b[3:0];

`ifdef ALU_SEQ_ZCHAIN_EN
    assign w_z_final = r_zacc & i_alu_flags[2];
`else
    assign w_z_final = i_alu_flags[2];
`endif

    //------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //------------------------------------------------------------------
    // FSM: next-state logic
    //------------------------------------------------------------------
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nxt = i_start ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    //------------------------------------------------------------------
    // FSM: outputs. ALU operands are zeroed outside RUN, while opcode
    // and bank keep showing the last latched values.
    //------------------------------------------------------------------
    always_comb begin
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_alu_enable = 1'b1;
        o_alu_a      = 4'h0;
        o_alu_b      = 4'h0;
        o_alu_cin    = 1'b0;
        case (r_state)
            S_RUN: begin
                o_busy       = 1'b1;
                o_alu_enable = 1'b0;
                o_alu_a      = w_nib_a;
                o_alu_b      = w_nib_b;
                // Nibble 0 takes the external carry; later nibbles ripple
                o_alu_cin    = (r_idx == '0) ? r_cin : r_carry;
            end
            S_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_alu_op   = r_op;
    assign o_alu_bank = r_bank;
    assign o_result   = r_result;
    assign o_flags    = r_flags;

    //------------------------------------------------------------------
    // Operand latch, nibble index and carry chain
    //------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= 3'd0;
            r_bank  <= 1'b0;
            r_cin   <= 1'b0;
            r_idx   <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_a     <= i_op_a;
            r_b     <= i_op_b;
            r_op    <= i_op;
            r_bank  <= i_bank;
            r_cin   <= i_cin;
            r_idx   <= '0;
            r_carry <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_carry <= i_alu_flags[0];
            r_idx   <= w_last ? '0 : r_idx + IW'(1);
        end
    end

    //------------------------------------------------------------------
    // Result and flag capture. Both only ever change in RUN, so they
    // hold across IDLE and DONE until the next accepted operation.
    //------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_result <= '0;
            r_flags  <= 4'h0;
        end else if (r_state == S_RUN) begin
            for (int n = 0; n < NIBBLES; n++) begin
                if (r_idx == IW'(n)) begin
                    r_result[n*4 +: 4] <= i_alu_result;
                end
            end
            if (w_last) begin
                r_flags <= {i_alu_flags[3], w_z_final, i_alu_flags[1], i_alu_flags[0]};
            end
        end
    end

`ifdef ALU_SEQ_ZCHAIN_EN
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_zacc <= 1'b1;
        end else if (w_accept) begin
            r_zacc <= 1'b1;
        end else if (r_state == S_RUN) begin
            r_zacc <= r_zacc & i_alu_flags[2];
        end
    end
`endif

endmodule
